// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small write-side FIFO
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock_in,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          TxD
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_next;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [BAUD_W-1:0]   baud_cnt, baud_next;
    logic [2:0]          bit_idx, bit_next;
    logic [7:0]          shift_reg, shift_next;
    logic                txd_next;
    logic                push, pop, bit_end;

    // full is the registered flag, so a write in a full cycle drops even if a pop happens
    assign push    = wr_en && !full;
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clock_in) begin
        if (push && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10: begin
                    fifo_count <= fifo_count + CNT_W'(1);
                    full       <= (fifo_count + CNT_W'(1) == CNT_W'(FIFO_DEPTH));
                    empty      <= 1'b0;
                end
                2'b01: begin
                    fifo_count <= fifo_count - CNT_W'(1);
                    full       <= 1'b0;
                    empty      <= (fifo_count == CNT_W'(1));
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BAUD_W'(1);
        bit_next   = bit_idx;
        shift_next = shift_reg;
        pop        = 1'b0;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done   = 1'b1;
                    baud_next = '0;
                    // chain straight into the next start bit when more data is queued
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[bit_next];
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            TxD       <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            TxD       <= txd_next;
        end
    end

endmodule
